// File: rtl/icfo_comp.sv
// Integer CFO compensation: ping-pong buffers FFT symbols and re-reads each one with a
// circularly shifted bin index taken from the latched iCFO_est offset.
module icfo_comp #(
   parameter int unsigned NFFT       = 256,
   parameter int unsigned LOG2N      = 8,
   parameter int unsigned DW         = 16,
   parameter int unsigned IFO_CENTER = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ena_i,
   input  logic [DW-1:0]    dat_i_Re,
   input  logic [DW-1:0]    dat_i_Im,
   input  logic             stb_i,
   input  logic [2:0]       ifoff_i,
   input  logic             ifoff_val_i,
   output logic [DW-1:0]    dat_o_Re,
   output logic [DW-1:0]    dat_o_Im,
   output logic             stb_o,
   output logic [LOG2N-1:0] dat_cnt_o,
   output logic             sym_done_o
);

   typedef enum logic [1:0] {StWaitOff, StIdle, StDrain} state_e;

   logic [2*DW-1:0]  mem_q [2*NFFT];

   state_e           state_q;
   logic             off_locked_q;
   logic [LOG2N-1:0] shift_q;
   logic [LOG2N-1:0] rshift_q;
   logic [LOG2N-1:0] wptr_q;
   logic             wbank_q;
   logic             rbank_q;
   logic [LOG2N-1:0] rk_q;
   logic [1:0]       full_q;
   logic [1:0]       full_d;

   logic             flush;
   logic             drain_last;
   logic             wr_ok;
   logic             wr_wrap;
   logic             next_full;
   logic [LOG2N-1:0] raddr;

   assign flush      = rst | ~ena_i;
   assign drain_last = (state_q == StDrain) && (rk_q == LOG2N'(NFFT - 1));
   // A bank may be refilled in the same clk that its last bin is read out.
   assign wr_ok      = ~flush && off_locked_q && stb_i &&
                       (~full_q[wbank_q] || (drain_last && (rbank_q == wbank_q)));
   assign wr_wrap    = wr_ok && (wptr_q == LOG2N'(NFFT - 1));
   assign next_full  = full_q[~rbank_q] || (wr_wrap && (wbank_q != rbank_q));
   assign raddr      = rk_q + rshift_q;

   always_comb begin
      full_d = full_q;
      if (drain_last) full_d[rbank_q] = 1'b0;
      if (wr_wrap)    full_d[wbank_q] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (wr_ok) mem_q[{wbank_q, wptr_q}] <= {dat_i_Re, dat_i_Im};
   end

   always_ff @(posedge clk) begin
      if (flush) begin
         state_q      <= StWaitOff;
         off_locked_q <= 1'b0;
         shift_q      <= '0;
         rshift_q     <= '0;
         wptr_q       <= '0;
         wbank_q      <= 1'b0;
         rbank_q      <= 1'b0;
         rk_q         <= '0;
         full_q       <= '0;
         dat_o_Re     <= '0;
         dat_o_Im     <= '0;
         stb_o        <= 1'b0;
         dat_cnt_o    <= '0;
         sym_done_o   <= 1'b0;
      end else begin
         if (ifoff_val_i && !off_locked_q) begin
            off_locked_q <= 1'b1;
            shift_q      <= LOG2N'(ifoff_i) - LOG2N'(IFO_CENTER);
         end
         if (wr_ok) begin
            wptr_q <= wptr_q + 1'b1;
            if (wr_wrap) wbank_q <= ~wbank_q;
         end
         full_q     <= full_d;
         stb_o      <= 1'b0;
         sym_done_o <= 1'b0;
         case (state_q)
            StWaitOff: begin
               if (off_locked_q) state_q <= StIdle;
            end
            StIdle: begin
               if (full_q[rbank_q]) begin
                  state_q  <= StDrain;
                  rk_q     <= '0;
                  rshift_q <= shift_q;
               end
            end
            StDrain: begin
               {dat_o_Re, dat_o_Im} <= mem_q[{rbank_q, raddr}];
               stb_o      <= 1'b1;
               dat_cnt_o  <= rk_q;
               sym_done_o <= drain_last;
               rk_q       <= rk_q + 1'b1;
               if (drain_last) begin
                  rbank_q <= ~rbank_q;
                  // Other bank ready: chain straight into its drain without a bubble.
                  if (next_full) rshift_q <= shift_q;
                  else           state_q  <= StIdle;
               end
            end
            default: state_q <= StWaitOff;
         endcase
      end
   end

endmodule
